// File: rtl/dmem_responder.sv
// dmem_responder: four word-interleaved SRAM banks behind a single
// request/response handshake for the CPU memory stage. Loads return after
// READ_LAT cycles. Stores and faulting accesses are acknowledged after one cycle.
module dmem_responder #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int ROW_W = ADDR_W - 4;
  localparam int DEPTH = 1 << ROW_W;
  // Initial WAIT count. When READ_LAT is 1 the load skips WAIT entirely.
  localparam logic [3:0] WAIT_INIT = 4'(READ_LAT - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic [31:0]        mem [0:3][0:DEPTH-1];

  logic [1:0]         req_bank;
  logic [ROW_W-1:0]   req_row;
  logic               req_err;
  logic               accept;
  logic               mem_we;
  logic [1:0]         rd_bank;
  logic [ROW_W-1:0]   rd_row;
  logic [31:0]        rd_word;

  // Request decode: the interleave puts consecutive words in consecutive banks.
  assign req_bank  = req_addr[3:2];
  assign req_row   = req_addr[ADDR_W-1:4];
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W] != '0);
  assign req_ready = (state_q != ST_WAIT);
  assign accept    = req_valid && req_ready;
  assign stall     = (accept && !req_we && !req_err) || (state_q == ST_WAIT);

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Read port address: the registered load address while waiting, else the live request.
  always_comb begin
    rd_bank = req_bank;
    rd_row  = req_row;
    if (state_q == ST_WAIT) begin
      rd_bank = bank_q;
      rd_row  = row_q;
    end else begin
      rd_bank = req_bank;
      rd_row  = req_row;
    end
    rd_word = mem[rd_bank][rd_row];
  end

  // Next-state and response logic; IDLE and RESP accept requests identically.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    row_d       = row_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_we      = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (req_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else if (req_we) begin
            mem_we      = 1'b1;
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else if (READ_LAT == 1) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_word;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
            bank_d  = req_bank;
            row_d   = req_row;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rd_word;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and response registers. A reset during WAIT discards the pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      bank_q      <= 2'd0;
      row_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bank array write port with per-byte-lane enables. Contents are not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && req_be[i]) begin
        mem[req_bank][req_row][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes expected responses
// computed from a word-addressed memory model, and a monitor on the falling
// edge pops and compares them. The monitor also checks ready, stall and data hold.
module tb_dmem_responder;

  localparam int ADDR_W   = 16;
  localparam int READ_LAT = 2;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [31:0] mm [int];
  bit          load_pending = 1'b0;
  int          load_t = 0;
  logic [31:0] last_rdata = 32'h0;

  dmem_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stall(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_W] != 16'h0000);
  endfunction

  // The responder is busy only strictly between a load's acceptance and its response.
  function automatic bit model_ready(input int c);
    return !(load_pending && c > load_t && c < load_t + READ_LAT);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    int          w;
    logic [31:0] tmp;
    while (!model_ready(cyc)) idle(1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    w         = int'(addr[ADDR_W-1:2]);
    e.err     = addr_err(addr);
    e.data    = 32'h0;
    e.cyc     = cyc + 1;
    if (!e.err && we) begin
      tmp = mm.exists(w) ? mm[w] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (be[i]) tmp[8*i +: 8] = wdata[8*i +: 8];
      mm[w] = tmp;
    end else if (!e.err) begin
      e.cyc        = cyc + READ_LAT;
      e.data       = mm[w];
      load_pending = 1'b1;
      load_t       = cyc;
    end
    sbq.push_back(e);
    idle(1);
    req_valid = 1'b0;
  endtask

  // Monitor: compare every falling edge against the scoreboard and the ready/stall model.
  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_stall;
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h1);
      chk("rst_stall", 32'(stall), 32'h0);
      last_rdata = 32'h0;
    end else begin
      exp_rdy   = model_ready(cyc);
      exp_stall = (req_valid && !req_we && !addr_err(req_addr) && exp_rdy) ||
                  (load_pending && cyc > load_t && cyc < load_t + READ_LAT);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("stall", 32'(stall), 32'(exp_stall));
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_rsp cyc=%0d actual=none required_at=%0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        chk("rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
        chk("rsp_rdata", rsp_rdata, sbq[0].data);
        last_rdata = sbq[0].data;
        void'(sbq.pop_front());
      end else begin
        chk("no_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rdata_hold", rsp_rdata, last_rdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          t;
    logic [31:0] a;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_be    = 4'h0;
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // Full-word store then load of the same word.
    issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    idle(3);

    // One word per bank, a single-lane partial store, then back-to-back loads.
    issue(1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF);
    issue(1'b1, 32'h0000_0004, 32'h5566_7788, 4'hF);
    issue(1'b1, 32'h0000_0008, 32'h99AA_BBCC, 4'hF);
    issue(1'b1, 32'h0000_000C, 32'hDDEE_FF00, 4'hF);
    issue(1'b1, 32'h0000_0004, 32'h0000_00AA, 4'h1);
    issue(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0);
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    issue(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    idle(2);

    // Misaligned load and out-of-range store; the latter must not alias word 0.
    issue(1'b0, 32'h0000_0102, 32'h0, 4'h0);
    issue(1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    idle(3);

    // Reset while a load is waiting: its response is dropped, data survives.
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    rst_n = 1'b0;
    void'(sbq.pop_back());
    load_pending = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    idle(2);

    // Randomized traffic over a small initialised window plus faulting addresses.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(1, 3));
        1:       a = 32'h0001_0000 | ($urandom & 32'hFFFF_FFFC);
        2:       a = 32'h0000_0100;
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    t = 0;
    while (sbq.size() > 0 && t < 50) begin
      idle(1);
      t++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain cyc=%0d actual=%0d_pending required=0", cyc, sbq.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
